decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001: Parameter RV_M, default 0, meaning 1 enables RV32M decode, 0 treats RV32M encodings as illegal.
REQ-002: Parameter DEPTH, default 2, meaning output buffer entries; legal values are 1 and 2.
REQ-003: Parameter ALU_OP_W, default 5, meaning ALU opcode width; it is fixed at 5 and independent of RV_M.
REQ-004: The block SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-005: Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  in_inst/in_pc valid
- in_ready  out  1  block accepts this cycle
- in_inst  in  32  instruction
- in_pc  in  32  instruction PC
- flush  in  1  discard all buffered entries
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_pc  out  32  PC of head
- out_rd, out_rs1, out_rs2  out  5 each  register indices
- out_immediate  out  32  decoded immediate
- out_alu_opcode  out  ALU_OP_W  ALU operation
- out_funct3  out  3  inst[14:12]
- out_ctrl  out  11  {write_en, alu_src1_from_pc, alu_src2_from_imm, mem_write_en, mem_read_en, lui_inst, store_inst, branch_inst, jal_inst, jalr_inst, illegal}
- illegal_count  out  8  saturating count of illegal instructions accepted

Function
REQ-006: Accept occurs when in_valid&&in_ready; pop occurs when out_valid&&out_ready.
REQ-007: Latency SHALL be one cycle: an instruction accepted in cycle N into an empty buffer presents out_valid=1 in cycle N+1.
REQ-008: in_ready SHALL be 1 iff occupancy<DEPTH, or occupancy==DEPTH and a pop occurs that cycle (DEPTH=2 only); it SHALL depend on no input other than out_ready.
REQ-009: The buffer SHALL be FIFO-ordered; a simultaneous accept and pop at full SHALL keep occupancy unchanged and preserve order.
REQ-010: Head outputs SHALL be held stable while out_valid=1 and out_ready=0.
REQ-011: Decode of LUI, OP-IMM, OP, STORE, LOAD, AUIPC, and BRANCH SHALL match the existing Jala control encoding; ALU opcodes zero-extend to {1'b0, 4-bit op}.
REQ-012: JAL SHALL assert write_en, alu_src1_from_pc, alu_src2_from_imm, and jal_inst, with immediate=J-immediate and alu_opcode=0.
REQ-013: JALR SHALL assert write_en, alu_src2_from_imm, and jalr_inst, with immediate=I-immediate and alu_opcode=0.
REQ-014: When RV_M=1 and OP has funct7=0000001, alu_opcode SHALL be {2'b10, funct3} with write_en=1.
REQ-015: Any other opcode or funct7 combination, including RV32M when RV_M=0, SHALL set illegal=1 with all other ctrl bits 0.
REQ-016: out_immediate SHALL be 0 (never X) for R-type and illegal instructions.
REQ-017: out_alu_opcode SHALL be 0 where the op is unused.
REQ-018: flush SHALL empty the buffer next cycle and take priority over an accept in the same cycle; the flushed-cycle accept is dropped.
REQ-019: flush SHALL NOT drive in_ready low.
REQ-020: illegal_count SHALL increment on each accepted illegal instruction, saturate at 255, and not be decremented by flush.

Reset
REQ-021: While rst_n=0, occupancy=0, out_valid=0, and illegal_count=0.
REQ-022: While rst_n=0, all data outputs SHALL be 0.
REQ-023: While rst_n=0, in_ready=1 after deassertion; a reset mid-stream SHALL discard all entries.

Structure
REQ-024: Opcode constants, ALU opcode encodings, and the out_ctrl bit positions SHALL live in the shared package jala_pkg.
REQ-025: The combinational decode SHALL be a sub-module, decode_comb, parametrised by RV_M; decode_stage SHALL contain only the buffer, handshake, and counter.

Verification
REQ-026: Decode check: 0x00500093 (addi x1,x0,5) -> next cycle out_valid=1, rd=1, immediate=5, alu_opcode=0, write_en=1, alu_src2_from_imm=1.
REQ-027: Decode check: 0x123450B7 (lui) -> immediate=0x12345000, lui_inst=1.
REQ-028: Decode check: 0x4030D093 (srai) -> alu_opcode=0x0D.
REQ-029: Decode check: 0x008000EF (jal x1,8) -> immediate=8, jal_inst=1.
REQ-030: Backpressure: out_ready=0 with three back-to-back instructions at DEPTH=2 -> in_ready=0 after two accepts; third accepted on the first pop; order A, B, C.
REQ-031: RV32M: 0x02208033 (mul) with RV_M=1 -> alu_opcode=0x10.
REQ-032: RV32M: 0x02208033 (mul) with RV_M=0 -> illegal=1; 300 illegal instructions -> illegal_count=255.
REQ-033: flush with buffer full plus a same-cycle accept -> out_valid=0 next cycle and the accepted instruction never appears.
REQ-034: Mid-operation reset: rst_n pulsed low asynchronously mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/jala_pkg.sv
// Shared Jala decode definitions: opcodes, ALU operation codes, control-bit
// positions and the buffered decode record.
package jala_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // 4-bit ALU ops are {funct7[5], funct3} for the base integer set
   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SLL  = 4'h1;
   localparam logic [3:0] ALU_SLT  = 4'h2;
   localparam logic [3:0] ALU_SLTU = 4'h3;
   localparam logic [3:0] ALU_SUB  = 4'h8;

   localparam int CTRL_W        = 11;
   localparam int CTRL_WE       = 10;
   localparam int CTRL_SRC1_PC  = 9;
   localparam int CTRL_SRC2_IMM = 8;
   localparam int CTRL_MEM_WE   = 7;
   localparam int CTRL_MEM_RE   = 6;
   localparam int CTRL_LUI      = 5;
   localparam int CTRL_STORE    = 4;
   localparam int CTRL_BRANCH   = 3;
   localparam int CTRL_JAL      = 2;
   localparam int CTRL_JALR     = 1;
   localparam int CTRL_ILLEGAL  = 0;

   typedef struct packed {
      logic [31:0]       pc;
      logic [4:0]        rd;
      logic [4:0]        rs1;
      logic [4:0]        rs2;
      logic [31:0]       imm;
      logic [4:0]        alu;
      logic [2:0]        funct3;
      logic [CTRL_W-1:0] ctrl;
   } entry_t;

   function automatic logic [4:0] alu_ext(input logic [3:0] op);
      return {1'b0, op};
   endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I (optionally RV32M) instruction decode into immediate,
// ALU operation and control bits.
module decode_comb
   import jala_pkg::*;
#(
   parameter int RV_M = 0
) (
   input  logic [31:0]       inst_i,
   output logic [31:0]       imm_o,
   output logic [4:0]        alu_op_o,
   output logic [CTRL_W-1:0] ctrl_o
);

   logic [6:0]  opc;
   logic [6:0]  f7;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        legal;

   assign opc   = inst_i[6:0];
   assign f7    = inst_i[31:25];
   assign f3    = inst_i[14:12];
   assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
   assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
   assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign imm_u = {inst_i[31:12], 12'h000};
   assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

   always_comb begin
      legal    = 1'b1;
      imm_o    = '0;
      alu_op_o = '0;
      ctrl_o   = '0;
      case (opc)
         OPC_LUI: begin
            ctrl_o[CTRL_WE]       = 1'b1;
            ctrl_o[CTRL_SRC2_IMM] = 1'b1;
            ctrl_o[CTRL_LUI]      = 1'b1;
            imm_o                 = imm_u;
         end
         OPC_AUIPC: begin
            ctrl_o[CTRL_WE]       = 1'b1;
            ctrl_o[CTRL_SRC1_PC]  = 1'b1;
            ctrl_o[CTRL_SRC2_IMM] = 1'b1;
            imm_o                 = imm_u;
         end
         OPC_JAL: begin
            ctrl_o[CTRL_WE]       = 1'b1;
            ctrl_o[CTRL_SRC1_PC]  = 1'b1;
            ctrl_o[CTRL_SRC2_IMM] = 1'b1;
            ctrl_o[CTRL_JAL]      = 1'b1;
            imm_o                 = imm_j;
         end
         OPC_JALR: begin
            legal                 = (f3 == 3'b000);
            ctrl_o[CTRL_WE]       = 1'b1;
            ctrl_o[CTRL_SRC2_IMM] = 1'b1;
            ctrl_o[CTRL_JALR]     = 1'b1;
            imm_o                 = imm_i;
         end
         OPC_BRANCH: begin
            // Branch compare: equality via SUB, ordering via SLT/SLTU
            ctrl_o[CTRL_BRANCH] = 1'b1;
            imm_o               = imm_b;
            case (f3)
               3'b000, 3'b001: alu_op_o = alu_ext(ALU_SUB);
               3'b100, 3'b101: alu_op_o = alu_ext(ALU_SLT);
               3'b110, 3'b111: alu_op_o = alu_ext(ALU_SLTU);
               default:        legal    = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            legal                 = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            ctrl_o[CTRL_WE]       = 1'b1;
            ctrl_o[CTRL_SRC2_IMM] = 1'b1;
            ctrl_o[CTRL_MEM_RE]   = 1'b1;
            imm_o                 = imm_i;
            alu_op_o              = alu_ext(ALU_ADD);
         end
         OPC_STORE: begin
            legal                 = (f3 < 3'b011);
            ctrl_o[CTRL_SRC2_IMM] = 1'b1;
            ctrl_o[CTRL_MEM_WE]   = 1'b1;
            ctrl_o[CTRL_STORE]    = 1'b1;
            imm_o                 = imm_s;
            alu_op_o              = alu_ext(ALU_ADD);
         end
         OPC_OP_IMM: begin
            ctrl_o[CTRL_WE]       = 1'b1;
            ctrl_o[CTRL_SRC2_IMM] = 1'b1;
            imm_o                 = imm_i;
            if (f3 == 3'b001) begin
               legal    = (f7 == 7'b0000000);
               alu_op_o = alu_ext(ALU_SLL);
            end else if (f3 == 3'b101) begin
               legal    = (f7 == 7'b0000000) || (f7 == 7'b0100000);
               alu_op_o = alu_ext({f7[5], f3});
            end else begin
               alu_op_o = alu_ext({1'b0, f3});
            end
         end
         OPC_OP: begin
            ctrl_o[CTRL_WE] = 1'b1;
            if (f7 == 7'b0000000) begin
               alu_op_o = alu_ext({1'b0, f3});
            end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
               alu_op_o = alu_ext({1'b1, f3});
            end else if (RV_M != 0 && f7 == 7'b0000001) begin
               alu_op_o = {2'b10, f3};
            end else begin
               legal = 1'b0;
            end
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         imm_o                = '0;
         alu_op_o             = '0;
         ctrl_o               = '0;
         ctrl_o[CTRL_ILLEGAL] = 1'b1;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: one-cycle decode into a small in-order output buffer with
// valid/ready handshake, flush, and a saturating illegal-instruction counter.
module decode_stage
   import jala_pkg::*;
#(
   parameter int RV_M     = 0,
   parameter int DEPTH    = 2,
   parameter int ALU_OP_W = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_inst,
   input  logic [31:0]         in_pc,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         out_pc,
   output logic [4:0]          out_rd,
   output logic [4:0]          out_rs1,
   output logic [4:0]          out_rs2,
   output logic [31:0]         out_immediate,
   output logic [ALU_OP_W-1:0] out_alu_opcode,
   output logic [2:0]          out_funct3,
   output logic [10:0]         out_ctrl,
   output logic [7:0]          illegal_count
);

   logic [31:0]       dec_imm;
   logic [4:0]        dec_alu;
   logic [CTRL_W-1:0] dec_ctrl;
   entry_t            new_e;
   entry_t [1:0]      ent_q, ent_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [7:0]        ill_q, ill_d;
   logic              accept, pop, full, wr_idx;

   decode_comb #(.RV_M(RV_M)) u_decode_comb (
      .inst_i   (in_inst),
      .imm_o    (dec_imm),
      .alu_op_o (dec_alu),
      .ctrl_o   (dec_ctrl)
   );

   assign new_e = '{pc: in_pc, rd: in_inst[11:7], rs1: in_inst[19:15], rs2: in_inst[24:20],
                    imm: dec_imm, alu: dec_alu, funct3: in_inst[14:12], ctrl: dec_ctrl};

   assign out_valid = (cnt_q != 2'd0);
   assign pop       = out_valid && out_ready;
   assign full      = (cnt_q == 2'(DEPTH));
   // Full buffer can take a new entry only when the head leaves this cycle
   assign in_ready  = !full || (DEPTH == 2 && out_ready);
   assign accept    = in_valid && in_ready;
   assign wr_idx    = (cnt_q == 2'd2) || (cnt_q == 2'd1 && !pop);

   always_comb begin
      ent_d = ent_q;
      cnt_d = cnt_q;
      ill_d = ill_q;
      if (flush) begin
         cnt_d = 2'd0;
      end else begin
         if (pop) ent_d[0] = ent_q[1];
         if (accept) ent_d[wr_idx] = new_e;
         cnt_d = cnt_q + 2'(accept) - 2'(pop);
         if (accept && new_e.ctrl[CTRL_ILLEGAL] && ill_q != 8'hFF) ill_d = ill_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_q <= '0;
         cnt_q <= 2'd0;
         ill_q <= 8'd0;
      end else begin
         ent_q <= ent_d;
         cnt_q <= cnt_d;
         ill_q <= ill_d;
      end
   end

   assign out_pc         = ent_q[0].pc;
   assign out_rd         = ent_q[0].rd;
   assign out_rs1        = ent_q[0].rs1;
   assign out_rs2        = ent_q[0].rs2;
   assign out_immediate  = ent_q[0].imm;
   assign out_alu_opcode = ent_q[0].alu;
   assign out_funct3     = ent_q[0].funct3;
   assign out_ctrl       = ent_q[0].ctrl;
   assign illegal_count  = ill_q;

endmodule
